// File: rtl/regwrite_sequencer_pkg.sv
// Shared definitions for the register-file write-back sequencer:
// FSM states, logical write-data sources and the mux select encoding.
package regwrite_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   localparam logic [3:0] SRC_ALU      = 4'd0;
   localparam logic [3:0] SRC_MEM      = 4'd1;
   localparam logic [3:0] SRC_PC4      = 4'd2;
   localparam logic [3:0] SRC_IMM      = 4'd3;
   localparam logic [3:0] SRC_HI       = 4'd4;
   localparam logic [3:0] SRC_LO       = 4'd5;
   localparam logic [3:0] SRC_SHIFT    = 4'd6;
   localparam logic [3:0] SRC_LUI      = 4'd7;
   localparam logic [3:0] SRC_MULT     = 4'd8;
   localparam logic [3:0] SRC_DIV      = 4'd9;
   localparam logic [3:0] SRC_SLT      = 4'd10;
   localparam logic [3:0] SRC_CONST227 = 4'd11;

   localparam int SP_REG_DEF   = 29;
   localparam int NUM_SRC_DEF  = 12;
   localparam int WAIT_MAX_DEF = 63;

   // Mux select bit 3 picks the lower bank (sources 0..7) when high.
   function automatic logic [3:0] enc_datasrc(input logic [3:0] src);
      return {~src[3], src[2:0]};
   endfunction

endpackage

// File: rtl/regwrite_sequencer_wb_timeout_counter.sv
// Six-bit wait counter with synchronous clear/enable and a terminal-count flag.
module wb_timeout_counter #(
   parameter logic [5:0] TC_VAL = 6'd62
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [5:0] cnt_r;

   // Counter register: clear wins over enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= 6'd0;
      end else if (clr) begin
         cnt_r <= 6'd0;
      end else if (en) begin
         cnt_r <= cnt_r + 6'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/regwrite_sequencer.sv
// Write-back port sequencer: SP init after reset, then request-driven
// register writes with optional wait on a multi-cycle unit.
module regwrite_sequencer
   import regwrite_sequencer_pkg::*;
#(
   parameter int SP_REG   = SP_REG_DEF,
   parameter int SP_SRC   = 11,
   parameter int NUM_SRC  = NUM_SRC_DEF,
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_dst,
   input  logic       wb_wait,
   input  logic       unit_done,
   output logic       wb_ready,
   output logic [3:0] DataSrc,
   output logic       RegWrite,
   output logic [4:0] WriteReg,
   output logic       init_done,
   output logic       wb_err
);

   state_t state_r;
   logic   cnt_clr_s;
   logic   cnt_en_s;
   logic   cnt_tc_s;

   assign cnt_clr_s = (state_r != ST_WAIT);
   assign cnt_en_s  = (state_r == ST_WAIT);

   // Terminal count one below WAIT_MAX so the timeout lands on the last WAIT cycle.
   wb_timeout_counter #(
      .TC_VAL (6'(WAIT_MAX - 1))
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .tc    (cnt_tc_s)
   );

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_INIT;
         DataSrc   <= 4'd0;
         RegWrite  <= 1'b0;
         WriteReg  <= 5'd0;
         wb_ready  <= 1'b0;
         init_done <= 1'b0;
         wb_err    <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               DataSrc   <= enc_datasrc(4'(SP_SRC));
               WriteReg  <= 5'(SP_REG);
               RegWrite  <= 1'b1;
               init_done <= 1'b1;
               state_r   <= ST_IDLE;
            end
            ST_IDLE: begin
               RegWrite <= 1'b0;
               wb_err   <= 1'b0;
               // First IDLE cycle after a write or error only re-arms wb_ready.
               if (!wb_ready) begin
                  wb_ready <= 1'b1;
               end else if (wb_req) begin
                  wb_ready <= 1'b0;
                  DataSrc  <= enc_datasrc(wb_src);
                  WriteReg <= wb_dst;
                  if (int'(wb_src) >= NUM_SRC) begin
                     wb_err <= 1'b1;
                  end else if (wb_wait) begin
                     state_r <= ST_WAIT;
                  end else begin
                     state_r <= ST_WRITE;
                  end
               end else begin
                  wb_ready <= 1'b1;
               end
            end
            ST_WAIT: begin
               RegWrite <= 1'b0;
               wb_err   <= 1'b0;
               if (unit_done) begin
                  state_r <= ST_WRITE;
               end else if (cnt_tc_s) begin
                  wb_err  <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_WRITE: begin
               RegWrite <= 1'b1;
               wb_err   <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               RegWrite <= 1'b0;
               wb_err   <= 1'b0;
               wb_ready <= 1'b0;
               state_r  <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: doc/regwrite_sequencer.md
Name: regwrite_sequencer

Overview:
- Sequences the register-file write-back port of the multicycle CPU.
- Accepts write-back requests from the main control FSM and waits for multi-cycle units (mult/div) when required.
- Translates a logical source index into the select code of the 11+1-input write-data mux, then pulses the register write enable.
- Performs the post-reset stack-pointer initialisation: writes constant 227 into register 29 before any other write.

Parameters:
- SP_REG, 29, destination register of the post-reset init write
- SP_SRC, 11, logical source index of the constant-227 mux input
- NUM_SRC, 12, number of legal logical sources (0..NUM_SRC-1)
- WAIT_MAX, 63, cycles to wait for unit_done before flagging a timeout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_req  in  1  write-back request, sampled only when wb_ready=1
- wb_src  in  4  logical data source index 0..11
- wb_dst  in  5  destination register number
- wb_wait  in  1  source is a multi-cycle unit; wait for unit_done
- unit_done  in  1  mult/div result valid (level or pulse)
- wb_ready  out  1  sequencer can accept a request
- DataSrc  out  4  mux select code
- RegWrite  out  1  register-file write enable, one-cycle pulse
- WriteReg  out  5  register-file write address
- init_done  out  1  SP init completed; sticky until reset
- wb_err  out  1  one-cycle pulse: illegal source or timeout

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state=INIT, DataSrc=0, RegWrite=0, WriteReg=0, wb_ready=0, init_done=0, wb_err=0, wait counter=0.
- Mux select encoding (fixed by the write-data mux):
  - Select bit 3 = 1 chooses sources 0..7; bit 3 = 0 chooses sources 8..11.
  - DataSrc = {~src[3], src[2:0]}. Examples: src 0 -> 4'b1000, src 7 -> 4'b1111, src 8 -> 4'b0000, src 11 -> 4'b0011.
- States:
  - INIT (entered on the first clock after reset deasserts): DataSrc=enc(SP_SRC), WriteReg=SP_REG, RegWrite=1 for exactly one cycle. Next state is IDLE, and init_done is set in the same transition.
  - IDLE: wb_ready=1, RegWrite=0.
    - On wb_req, latch wb_src, wb_dst and wb_wait; drive DataSrc=enc(wb_src) and WriteReg=wb_dst on the next cycle. wb_ready drops that cycle.
    - If wb_src >= NUM_SRC: pulse wb_err, no write, stay in IDLE (wb_ready is back high after one cycle).
    - If wb_wait=0: go to WRITE.
    - If wb_wait=1: go to WAIT, counter=0.
  - WAIT: DataSrc/WriteReg held stable; counter increments each cycle.
    - unit_done=1 -> go to WRITE.
    - Counter reaches WAIT_MAX without unit_done -> pulse wb_err, go to IDLE, no write.
  - WRITE: RegWrite=1 for one cycle with DataSrc/WriteReg stable (the mux settles since the preceding cycle), then go to IDLE.
- Latency:
  - Request without wait: request accepted at edge N, RegWrite high in cycle N+1..N+2 (one cycle after the select is set up).
  - Request with wait: RegWrite is asserted the cycle after unit_done is sampled.
- Throughput: one write per 3 cycles minimum (accept, setup, write). The next request is accepted on the first IDLE cycle.
- Boundary conditions:
  - wb_req while wb_ready=0: ignored. The requester holds it.
  - wb_req during INIT: ignored.
  - unit_done asserted in the same cycle the request is accepted: not counted. Only unit_done sampled in WAIT is honoured.
  - wb_dst=0: the write is still issued. The register file discards writes to r0.
  - wb_err and RegWrite are never high in the same cycle.
  - Reset asserted mid-operation: immediate return to reset values. RegWrite drops asynchronously and the SP init reruns after release.

Decomposition:
- Shared package (cpu_pkg):
  - State enum {INIT, IDLE, WAIT, WRITE}.
  - Logical source index constants (SRC_ALU..SRC_CONST227=11).
  - Function enc_datasrc(src).
  - SP_REG constant.
- Sub-module wb_timeout_counter: a 6-bit counter with clear, enable and terminal-count output.
- FSM and output registers stay in the top module.

Test Plan:
- Reset release -> one cycle with RegWrite=1, WriteReg=29, DataSrc=4'b0011; then init_done=1 and wb_ready=1.
- wb_req with src=2, dst=8, wait=0 -> DataSrc=4'b1010, WriteReg=8; RegWrite pulses exactly one cycle, 2 cycles after acceptance; wb_ready returns to 1.
- wb_req with src=9, dst=5, wait=1; unit_done after 10 cycles -> DataSrc=4'b0001 held throughout WAIT; RegWrite pulses the cycle after unit_done.
- wb_req with src=13 -> wb_err pulses once, no RegWrite, wb_ready back to 1. Separately, wait=1 with no unit_done -> wb_err after 63 WAIT cycles, no write.
- Back-to-back requests src=0 then src=8 with wb_req held high -> two RegWrite pulses with DataSrc 4'b1000 then 4'b0000, never overlapping.
- Reset asserted during WAIT -> all outputs cleared immediately; after release, the SP init write repeats before any further request is accepted.
